mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder in front of a single-port RAM.
// A request is latched, held for WAIT_CYCLES extra cycles, then the access
// is performed and acknowledged with a one-cycle ack pulse. Addresses with
// any bit set above ADDR_W are flagged with err and never touch the RAM.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] adr,
  input  logic [15:0] writedata,
  output logic [15:0] memdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [3:0]        cnt_q,     cnt_d;
  logic [15:0]       adr_q,     adr_d;
  logic              we_q,      we_d;
  logic [15:0]       wdata_q,   wdata_d;
  logic [15:0]       memdata_q, memdata_d;
  logic              ack_q,     ack_d;
  logic              err_q,     err_d;
  logic              busy_q,    busy_d;

  logic              accept_s;
  logic              in_range_s;
  logic [ADDR_W-1:0] idx_s;
  logic              mem_we_s;

  logic [15:0]       mem [0:DEPTH-1];

  // Next-state, datapath latch, RAM access decode and reset override.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    memdata_d = memdata_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    mem_we_s  = 1'b0;

    // Shift form keeps the range check legal even when ADDR_W is 16.
    in_range_s = ((adr_q >> ADDR_W) == 16'd0);
    idx_s      = adr_q[ADDR_W-1:0];

    // The edge that leaves RESP also serves as an acceptance edge, so a
    // held req sustains one access every WAIT_CYCLES+2 cycles.
    accept_s = req && ((state_q == ST_IDLE) || (state_q == ST_RESP));

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          err_d   = ~in_range_s;
          if (we_q) begin
            mem_we_s = in_range_s;
          end else if (in_range_s) begin
            memdata_d = mem[idx_s];
          end else begin
            memdata_d = 16'h0000;
          end
        end
      end
      ST_RESP: begin
        if (accept_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      adr_d   = adr;
      we_d    = we;
      wdata_d = writedata;
      cnt_d   = 4'(WAIT_CYCLES);
    end else begin
      adr_d   = adr_d;
    end

    if (reset) begin
      state_d   = ST_IDLE;
      cnt_d     = 4'd0;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      memdata_d = 16'h0000;
      mem_we_s  = 1'b0;
    end else begin
      mem_we_s  = mem_we_s;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    adr_q     <= adr_d;
    we_q      <= we_d;
    wdata_q   <= wdata_d;
    memdata_q <= memdata_d;
    ack_q     <= ack_d;
    err_q     <= err_d;
    busy_q    <= busy_d;
  end

  // RAM write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[idx_s] <= wdata_q;
    end
  end

  assign memdata = memdata_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
